// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out handshake bundle for sipo_deserializer.
// Serial side: a bit moves when s_valid && s_ready; parallel side: a word moves when p_valid && p_ready.
interface sipo_deserializer_if #(
    parameter int width = 4
);
    logic             s_in;
    logic             s_valid;
    logic             s_ready;
    logic [width-1:0] p_out;
    logic             p_valid;
    logic             p_ready;
    logic             par_err;

    // Producer of serial bits and consumer of parallel words.
    modport master (
        output s_in,
        output s_valid,
        output p_ready,
        input  s_ready,
        input  p_out,
        input  p_valid,
        input  par_err
    );

    // The deserializer itself.
    modport slave (
        input  s_in,
        input  s_valid,
        input  p_ready,
        output s_ready,
        output p_out,
        output p_valid,
        output par_err
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Collects serial bits into width-bit words behind a one-word output holding register.
// Optional even-parity trailer bit per frame is enabled by defining SIPO_PARITY_EN.
module sipo_deserializer #(
    parameter int width     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    sipo_deserializer_if.slave  bus,
    output logic                state_dbg
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME_LEN = width + 1;
`else
    localparam int FRAME_LEN = width;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [width-1:0] sh;
    logic [width-1:0] sh_shift;
    logic [width-1:0] word_done;
    logic [CNT_W-1:0] cnt;
    logic [width-1:0] p_out_q;
    logic             p_valid_q;
    logic             accept;
    logic             last_bit;
    logic             data_bit;
    logic             out_free;
    logic             load_direct;
    logic             load_hold;

    always_comb begin
        sh_shift    = MSB_FIRST ? {sh[width-2:0], bus.s_in} : {bus.s_in, sh[width-1:1]};
        accept      = (state == COLLECT) && bus.s_valid;
        last_bit    = accept && (cnt == CNT_W'(FRAME_LEN - 1));
`ifdef SIPO_PARITY_EN
        // The trailing parity bit is not shifted in, so the word is already complete in sh.
        data_bit    = accept && !last_bit;
        word_done   = sh;
`else
        data_bit    = accept;
        word_done   = sh_shift;
`endif
        out_free    = !p_valid_q || bus.p_ready;
        load_direct = last_bit && out_free;
        load_hold   = (state == HOLD) && out_free;

        state_nxt = state;
        case (state)
            COLLECT: if (last_bit && !out_free) state_nxt = HOLD;
            HOLD:    if (out_free)              state_nxt = COLLECT;
            default:                            state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh  <= '0;
            cnt <= '0;
        end else begin
            if (data_bit) begin
                sh <= sh_shift;
            end
            if (accept) begin
                cnt <= last_bit ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // A load on the same edge as a drain keeps p_valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_out_q   <= '0;
            p_valid_q <= 1'b0;
        end else if (load_direct) begin
            p_out_q   <= word_done;
            p_valid_q <= 1'b1;
        end else if (load_hold) begin
            p_out_q   <= sh;
            p_valid_q <= 1'b1;
        end else if (bus.p_ready) begin
            p_valid_q <= 1'b0;
        end
    end

`ifdef SIPO_PARITY_EN
    logic par_acc;
    logic par_err_q;

    // par_acc runs over the frame; while in HOLD it already holds the final error bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_acc   <= 1'b0;
            par_err_q <= 1'b0;
        end else if (load_hold) begin
            par_err_q <= par_acc;
            par_acc   <= 1'b0;
        end else if (load_direct) begin
            par_err_q <= par_acc ^ bus.s_in;
            par_acc   <= 1'b0;
        end else if (accept) begin
            par_acc   <= par_acc ^ bus.s_in;
        end
    end

    assign bus.par_err = par_err_q;
`else
    assign bus.par_err = 1'b0;
`endif

    assign bus.s_ready = (state == COLLECT);
    assign bus.p_out   = p_out_q;
    assign bus.p_valid = p_valid_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one stimulus stream
// and are checked every cycle against a word-occupancy reference model.
module tb_sipo_deserializer;

    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic clk = 1'b0;
    logic rst;
    logic dbg_m;
    logic dbg_l;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.width(W)) bus_m ();
    sipo_deserializer_if #(.width(W)) bus_l ();

    sipo_deserializer #(.width(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_m.slave),
        .state_dbg (dbg_m)
    );

    sipo_deserializer #(.width(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_l.slave),
        .state_dbg (dbg_l)
    );

    // Scoreboard: completed words awaiting consumption, oldest first.
    logic [W-1:0] exp_msb_q[$];
    logic [W-1:0] exp_lsb_q[$];
    logic         exp_err_q[$];
    int           fr_n;
    logic [W-1:0] fr_msb;
    logic [W-1:0] fr_lsb;
    logic         fr_par;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_msb_q.delete();
        exp_lsb_q.delete();
        exp_err_q.delete();
        fr_n   = 0;
        fr_msb = '0;
        fr_lsb = '0;
        fr_par = 1'b0;
    endtask

    // At most two words can be buffered: one on the output, one waiting in the shifter.
    task automatic model_update(input logic v, input logic b, input logic pr);
        int occ;
        occ = exp_msb_q.size();
        if (occ >= 1 && pr) begin
            void'(exp_msb_q.pop_front());
            void'(exp_lsb_q.pop_front());
            void'(exp_err_q.pop_front());
        end
        if (v && occ < 2) begin
            if (fr_n < W) begin
                fr_msb = {fr_msb[W-2:0], b};
                fr_lsb[fr_n] = b;
            end
            fr_par = fr_par ^ b;
            fr_n++;
            if (fr_n == L) begin
                exp_msb_q.push_back(fr_msb);
                exp_lsb_q.push_back(fr_lsb);
`ifdef SIPO_PARITY_EN
                exp_err_q.push_back(fr_par);
`else
                exp_err_q.push_back(1'b0);
`endif
                fr_n   = 0;
                fr_msb = '0;
                fr_lsb = '0;
                fr_par = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        int occ;
        occ = exp_msb_q.size();
        check_val("s_ready_msb", bus_m.s_ready, occ < 2);
        check_val("s_ready_lsb", bus_l.s_ready, occ < 2);
        check_val("p_valid_msb", bus_m.p_valid, occ >= 1);
        check_val("p_valid_lsb", bus_l.p_valid, occ >= 1);
        check_val("hold_msb", dbg_m, occ == 2);
        if (occ >= 1) begin
            check_val("p_out_msb", bus_m.p_out, exp_msb_q[0]);
            check_val("p_out_lsb", bus_l.p_out, exp_lsb_q[0]);
            check_val("par_err_msb", bus_m.par_err, exp_err_q[0]);
            check_val("par_err_lsb", bus_l.par_err, exp_err_q[0]);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic pr);
        bus_m.s_valid = v;
        bus_m.s_in    = b;
        bus_m.p_ready = pr;
        bus_l.s_valid = v;
        bus_l.s_in    = b;
        bus_l.p_ready = pr;
    endtask

    task automatic step(input logic v, input logic b, input logic pr);
        @(negedge clk);
        check_outputs();
        drive(v, b, pr);
        model_update(v, b, pr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        model_clear();
        #1;
        check_val("rst_p_out_msb", bus_m.p_out, '0);
        check_val("rst_p_out_lsb", bus_l.p_out, '0);
        check_val("rst_p_valid", bus_m.p_valid, 1'b0);
        check_val("rst_par_err", bus_m.par_err, 1'b0);
        check_val("rst_s_ready", bus_m.s_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // data[W-1] is sent first; the parity bit follows only in parity builds.
    task automatic send_frame(input logic [W-1:0] data, input logic par, input int gap, input logic pr);
        for (int i = 0; i < W; i++) begin
            step(1'b1, data[W-1-i], pr);
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), pr);
        end
`ifdef SIPO_PARITY_EN
        step(1'b1, par, pr);
`else
        if (par === 1'bx) $display("parity argument unused");
`endif
    endtask

    initial begin
        int pr_pct;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        model_clear();
        repeat (2) @(negedge clk);
        do_reset();

        // Basic MSB-first word, single-cycle valid with p_ready high.
        send_frame(4'b1011, 1'b1, 0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_val("basic_word", bus_m.p_out, 4'b1011);
        step(1'b0, 1'b0, 1'b1);

        // LSB-first: bits 1,1,0,1 assemble to 1011.
        send_frame(4'b1101, 1'b1, 0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_val("lsb_word", bus_l.p_out, 4'b1011);
        step(1'b0, 1'b0, 1'b1);

        // Back-pressure: second word held in the shifter until one p_ready pulse.
        send_frame(4'b1011, 1'b1, 0, 1'b0);
        send_frame(4'b0110, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_val("bp_s_ready_low", bus_m.s_ready, 1'b0);
        check_val("bp_first_held", bus_m.p_out, 4'b1011);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check_val("bp_second_word", bus_m.p_out, 4'b0110);
        check_val("bp_s_ready_back", bus_m.s_ready, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // s_valid gaps between bits.
        send_frame(4'b1011, 1'b1, 2, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_val("gap_word", bus_m.p_out, 4'b1011);
        step(1'b0, 1'b0, 1'b1);

        // Reset after two accepted bits discards the partial frame.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        do_reset();
        send_frame(4'b0110, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_val("post_rst_word", bus_m.p_out, 4'b0110);
        step(1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
        send_frame(4'b1011, 1'b1, 0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_val("par_good_err", bus_m.par_err, 1'b0);
        send_frame(4'b1011, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_val("par_bad_err", bus_m.par_err, 1'b1);
        check_val("par_bad_word", bus_m.p_out, 4'b1011);
        step(1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic with varying downstream readiness and rare resets.
        pr_pct = 100;
        for (int c = 0; c < 2000; c++) begin
            if (c % 64 == 0) pr_pct = $urandom_range(0, 4) * 25;
            if ($urandom_range(0, 499) == 0) do_reset();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < pr_pct));
        end
        step(1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in/parallel-out front end for the parallel register pipeline. It collects `width` serial bits into one word and presents that word on a parallel output with a valid/ready handshake. It sits directly upstream of the parallel-in/parallel-out register stage and feeds `p_out` straight into that stage's parallel input. A one-word output holding register lets it assemble the next word while the current one waits. Back-pressure is applied to the serial side only when both the holding register and the shift register are full.

## Interface
- `width`, default 4: data bits per word; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `p_out[width-1]`; 0 means it lands in `p_out[0]`.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `s_in`  input  1  serial data bit.
- `s_valid`  input  1  `s_in` is valid this cycle.
- `s_ready`  output  1  the block accepts a bit this cycle; a bit transfers when `s_valid && s_ready`.
- `p_out`  output  `width`  assembled word, stable while `p_valid` is high.
- `p_valid`  output  1  `p_out` holds an unconsumed word.
- `p_ready`  input  1  downstream takes the word; transfer when `p_valid && p_ready`.
- `par_err`  output  1  parity error flag, qualified by `p_valid` (see Configuration).

## Operation
- Internal state:
  - `sh`: `width`-bit shift register.
  - `cnt`: bit counter.
  - Two-state FSM: `COLLECT`, `HOLD`.
  - Output holding register: drives `p_out`, `p_valid`, `par_err`.
- Reset state (async, on `rst` low):
  - `sh=0`, `cnt=0`, FSM = `COLLECT`.
  - `p_out=0`, `p_valid=0`, `par_err=0`.
  - `s_ready` = 1 from the first cycle after reset.
- `s_ready` = (FSM == `COLLECT`); decoded from registered state only, with no path from `s_valid` or `p_ready`.
- On each accepted bit:
  - `MSB_FIRST=1`: `sh <= {sh[width-2:0], s_in}`.
  - `MSB_FIRST=0`: `sh <= {s_in, sh[width-1:1]}`.
  - `cnt` increments.
- Frame length L = `width` (L = `width`+1 with parity). When the accepted bit is the last of a frame (`cnt == L-1`):
  - `cnt` wraps to 0.
  - If the output is free (`!p_valid`) or draining (`p_valid && p_ready`) in the same cycle, the completed word loads into `p_out` and `p_valid` = 1. The FSM stays in `COLLECT`.
  - Otherwise the completed word stays in `sh` and the FSM moves to `HOLD`.
- In `HOLD`:
  - No bits are accepted.
  - When the output is free or draining, `sh` loads into `p_out`, `p_valid` stays or becomes 1, and the FSM returns to `COLLECT`.
- `p_valid` clears on `p_valid && p_ready` unless a load happens on the same edge; a same-edge load takes priority and `p_valid` remains 1.
- `p_out` changes only on a load. It never changes while `p_valid=1 && !p_ready`.
- Gaps in `s_valid` leave `sh` and `cnt` unchanged. There is no timeout.
- Reset mid-frame discards partial bits and any pending or held word.

## Timing
- Latency: the word is visible on `p_out` with `p_valid=1` immediately after the clock edge that accepts the last bit. That is 1 cycle after the last bit is presented, provided the output is free.
- Throughput: one bit per cycle sustained when `p_ready` stays high. There are no bubbles between words.
- Back-pressure: `s_ready` falls on the edge that completes a word while the output is held. It rises on the edge after the output is drained, which is the same edge that loads from `HOLD`.
- `p_ready` may be high while `p_valid` is low; this has no effect.

## Configuration
- `SIPO_PARITY_EN` defined:
  - Each frame carries `width` data bits followed by one even-parity bit, which is not stored in `p_out`.
  - `par_err` = XOR of the data bits and the parity bit. It loads alongside `p_out` and is meaningful only while `p_valid`=1.
  - A word with `par_err=1` is still delivered.
- `SIPO_PARITY_EN` undefined:
  - Frames are `width` bits.
  - `par_err` is held at 0.

## Test plan
- Basic MSB-first, `width`=4, `p_ready`=1: bits 1,0,1,1 on consecutive cycles → after the 4th accepting edge, `p_out`=4'b1011 and `p_valid`=1 for exactly one cycle.
- LSB-first (`MSB_FIRST`=0): bits 1,1,0,1 → `p_out`=4'b1011.
- Back-pressure with `p_ready`=0: send 1011 then 0110.
  - First word is held on `p_out`.
  - `s_ready` drops after the 8th bit.
  - Raise `p_ready` for one cycle → 1011 is consumed and `p_out`=0110 on the same edge, with `p_valid` staying 1 and `s_ready` returning to 1.
- `s_valid` gaps: bits 1,0,1,1 with idle cycles between them → identical result to the basic case; `cnt` is frozen during the gaps.
- Reset mid-frame: after 2 accepted bits, pulse `rst` low → all outputs 0; the next bits 0,1,1,0 produce `p_out`=4'b0110.
- With `SIPO_PARITY_EN`: send 1011 with parity bit 1 → `par_err`=0; send 1011 with parity bit 0 → `par_err`=1, and `p_out`=1011 in both cases.
